bcm_spike_sequencer: RTL
========================

# bcm_spike_sequencer

Programmable pre/post spike-train controller that drives the `pre`/`post` inputs of one BCM/STDP synapse. It replays a fixed-length spike pattern in two phases: a fast phase with a short inter-spike gap, then a slow phase with a long gap. Each phase has its own repeat count. After every issued spike it emits a capture strobe, so a monitor can sample the synapse weight `W`. It replaces hand-timed stimulus and sits directly in front of the synapse instance.

## Interface
- `PAT_LEN`, 7: number of spike events per pattern.
- `PULSE_W`, 1: cycles each `pre`/`post` pulse is held high (≥1).
- `CNT_W`, 16: width of the gap configuration and the gap counter.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; accepted only in IDLE.
- `abort` in 1: terminate the run; takes priority over `start`.
- `pattern` in PAT_LEN: bit i selects event i. 0 = pre spike, 1 = post spike. Bit 0 is issued first.
- `gap_fast` in CNT_W: idle cycles after each pulse in the fast phase.
- `gap_slow` in CNT_W: idle cycles after each pulse in the slow phase.
- `fast_reps` in 8: number of pattern repetitions in the fast phase.
- `slow_reps` in 8: number of pattern repetitions in the slow phase.
- `pre` out 1: pre-synaptic spike to the synapse.
- `post` out 1: post-synaptic spike to the synapse.
- `busy` out 1: high while a run is in progress.
- `done` out 1: one-cycle pulse at normal completion.
- `phase` out 1: 0 = fast, 1 = slow. Valid while `busy`.
- `evt_cnt` out 16: spikes issued since the last accepted `start`. Saturates at 16'hFFFF.
- `sample` out 1: one-cycle weight-capture strobe.

## Operation
- States are IDLE, PULSE, GAP and DONE.
- Reset forces state IDLE. All outputs reset to 0: `pre`, `post`, `busy`, `done`, `phase`, `evt_cnt` = 0, `sample`.
- IDLE → PULSE when `start`=1 and `abort`=0. On that edge:
  - latch `pattern`, both gaps and both rep counts;
  - clear `evt_cnt`, the event index and the rep counter;
  - set `phase`=0, or `phase`=1 if `fast_reps`=0.
- IDLE → DONE when `start` is accepted with `fast_reps`=`slow_reps`=0. No pulses are issued.
- PULSE:
  - `pre`=~`pattern`[idx] and `post`=`pattern`[idx] for exactly PULSE_W cycles;
  - `evt_cnt` increments once per event, on entry to PULSE;
  - after the last pulse cycle, go to GAP, or to the next step directly if the current gap is 0.
- GAP:
  - `pre`=`post`=0 for the current phase's gap count, in cycles;
  - then advance: idx+1. After idx=PAT_LEN-1, wrap idx to 0 and increment the rep counter;
  - when the rep counter reaches the phase's rep count, switch to slow (clearing the rep counter), or go to DONE if the slow phase is finished or `slow_reps`=0;
  - otherwise go back to PULSE.
- A gap follows every event, including the last event of the run.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE.
- `abort`=1 in any non-IDLE state:
  - next state is IDLE;
  - `pre`/`post`/`busy` drop on that edge;
  - `done` is not asserted;
  - `evt_cnt` holds its value.
- `start` while `busy` is ignored. Changes to config inputs during a run have no effect until the next `start`.
- `rst` has priority over everything, including in mid-pulse.

## Timing
- Call the edge that accepts `start` edge 0.
- `busy` and the first pulse are high from edge 0 onward, i.e. in cycle 1.
- Event k of a phase with gap G starts (PULSE_W+G) cycles after event k-1.
- Fast phase length = `fast_reps`·PAT_LEN·(PULSE_W+`gap_fast`) cycles. Slow phase length is the same formula with `slow_reps` and `gap_slow`.
- `done` is high in cycle 1 + fast length + slow length.
- `sample` pulses in the cycle right after each pulse's final cycle. It is suppressed if `abort` or `rst` occurs in that cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `SEQ_SAMPLE_EN` defined: the `sample` strobe is generated as described above.
- `SEQ_SAMPLE_EN` undefined: `sample` is tied to 0 and its logic is removed. All other behaviour is unchanged.

## Test plan
- **Reset:** hold `rst`=1 for 5 cycles with `start`=1 → all outputs 0 and no pulses. Release `rst` with `start`=0 → remains IDLE.
- **Fast phase only:** `pattern`=7'h5A, `gap_fast`=10, `fast_reps`=1, `slow_reps`=0, PULSE_W=1.
  - Expect pre, post, pre, post, post, pre, post in cycles 1, 12, 23, 34, 45, 56, 67.
  - `done` in cycle 78; `evt_cnt`=7.
  - With `SEQ_SAMPLE_EN`, `sample` in cycles 2, 13, …, 68.
- **Two phases:** `fast_reps`=2, `gap_fast`=10, `slow_reps`=1, `gap_slow`=50.
  - 14 events spaced 11 cycles with `phase`=0, then 7 events spaced 51 cycles with `phase`=1.
  - `done` in cycle 512; `evt_cnt`=21.
- **Zero reps:** `fast_reps`=`slow_reps`=0, `start` → `done` in cycle 1, `busy` never high, `evt_cnt`=0, `pre`/`post` stay 0.
- **Abort:** assert `abort` in the gap after event 3 → IDLE next edge, `busy`=0, no `done`, `evt_cnt` holds 3.
  - `start` and `abort` asserted together in IDLE → `start` is ignored.
- **Mid-run `start` and reset:** `start` pulsed mid-run → no restart and `evt_cnt` unaffected. Then `rst` during a pulse → `pre`/`post` low on the next edge and all outputs 0.

Source files
------------

// File: rtl/bcm_spike_sequencer.sv
// bcm_spike_sequencer: two-phase (fast/slow) pre/post spike-train generator for one BCM/STDP synapse.
// Define SEQ_SAMPLE_EN to generate the o_sample weight-capture strobe; otherwise it is tied to 0.
module bcm_spike_sequencer #(
   parameter int PAT_LEN = 7,
   parameter int PULSE_W = 1,
   parameter int CNT_W   = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [PAT_LEN-1:0] i_pattern,
   input  logic [CNT_W-1:0]   i_gap_fast,
   input  logic [CNT_W-1:0]   i_gap_slow,
   input  logic [7:0]         i_fast_reps,
   input  logic [7:0]         i_slow_reps,
   output logic               o_pre,
   output logic               o_post,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_phase,
   output logic [15:0]        o_evt_cnt,
   output logic               o_sample
);
   localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
   localparam int PW_W  = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);
   localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PULSE_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_t;

   state_t             r_state, w_state_nxt;
   logic [PAT_LEN-1:0] r_pattern;
   logic [CNT_W-1:0]   r_gap_fast, r_gap_slow, r_gap_cnt;
   logic [7:0]         r_fast_reps, r_slow_reps, r_rep;
   logic [IDX_W-1:0]   r_idx;
   logic [PW_W-1:0]    r_pw_cnt;
   logic               r_phase;
   logic [15:0]        r_evt_cnt;

   logic               w_accept, w_zero, w_pw_last, w_last_idx;
   logic               w_phase_end, w_run_end, w_advance;
   logic [CNT_W-1:0]   w_gap;
   logic [7:0]         w_cur_reps, w_rep_next;

   assign w_accept    = (r_state == S_IDLE) && i_start && !i_abort;
   assign w_zero      = (i_fast_reps == 8'd0) && (i_slow_reps == 8'd0);
   assign w_pw_last   = (r_pw_cnt == PW_LAST);
   assign w_last_idx  = (r_idx == IDX_LAST);
   assign w_gap       = r_phase ? r_gap_slow : r_gap_fast;
   assign w_cur_reps  = r_phase ? r_slow_reps : r_fast_reps;
   assign w_rep_next  = r_rep + 8'd1;
   assign w_phase_end = w_last_idx && (w_rep_next == w_cur_reps);
   assign w_run_end   = w_phase_end && (r_phase || (r_slow_reps == 8'd0));
   // One event slot is over: either a zero-gap pulse ended or the gap ran out
   assign w_advance   = ((r_state == S_PULSE) && w_pw_last && (w_gap == '0)) ||
                        ((r_state == S_GAP) && (r_gap_cnt == '0));

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_zero ? S_DONE : S_PULSE;
         S_PULSE: if (w_pw_last) begin
                     if (w_gap != '0) w_state_nxt = S_GAP;
                     else             w_state_nxt = w_run_end ? S_DONE : S_PULSE;
                  end
         S_GAP:   if (r_gap_cnt == '0) w_state_nxt = w_run_end ? S_DONE : S_PULSE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (i_abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
   end

   always_comb begin
      o_pre     = (r_state == S_PULSE) && !r_pattern[r_idx];
      o_post    = (r_state == S_PULSE) &&  r_pattern[r_idx];
      o_busy    = (r_state == S_PULSE) || (r_state == S_GAP);
      o_done    = (r_state == S_DONE);
      o_phase   = r_phase;
      o_evt_cnt = r_evt_cnt;
   end

   // Run configuration is captured once per accepted start and frozen for the run
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_pattern   <= i_pattern;
         r_gap_fast  <= i_gap_fast;
         r_gap_slow  <= i_gap_slow;
         r_fast_reps <= i_fast_reps;
         r_slow_reps <= i_slow_reps;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idx     <= '0;
         r_rep     <= '0;
         r_pw_cnt  <= '0;
         r_gap_cnt <= '0;
         r_phase   <= 1'b0;
         r_evt_cnt <= '0;
      end else if (w_accept) begin
         r_idx     <= '0;
         r_rep     <= '0;
         r_pw_cnt  <= '0;
         r_phase   <= (i_fast_reps == 8'd0);
         r_evt_cnt <= w_zero ? 16'd0 : 16'd1;
      end else if (!i_abort) begin
         if (r_state == S_PULSE) begin
            if (w_pw_last) begin
               r_pw_cnt  <= '0;
               r_gap_cnt <= w_gap - 1'b1;
            end else begin
               r_pw_cnt  <= r_pw_cnt + 1'b1;
            end
         end
         if ((r_state == S_GAP) && (r_gap_cnt != '0)) r_gap_cnt <= r_gap_cnt - 1'b1;
         if (w_advance) begin
            if (w_last_idx) begin
               r_idx <= '0;
               if (w_phase_end) begin
                  r_rep <= '0;
                  if (!w_run_end) r_phase <= 1'b1;
               end else begin
                  r_rep <= w_rep_next;
               end
            end else begin
               r_idx <= r_idx + 1'b1;
            end
            // The event counter counts pulse entries and sticks at full scale
            if (!w_run_end && (r_evt_cnt != 16'hFFFF)) r_evt_cnt <= r_evt_cnt + 16'd1;
         end
      end
   end

`ifdef SEQ_SAMPLE_EN
   logic r_sample;
   always_ff @(posedge i_clk) begin
      if (i_rst) r_sample <= 1'b0;
      else       r_sample <= (r_state == S_PULSE) && w_pw_last && !i_abort;
   end
   assign o_sample = r_sample;
`else
   assign o_sample = 1'b0;
`endif

endmodule
